// File: rtl/pmu_ahb_arbiter.sv
// Round-robin arbiter and AHB-lite master sequencer for the PMU slave port.
// Serialises single-word requests from N_REQ requesters into non-pipelined
// SINGLE/NONSEQ transfers. Read data and error status are returned with a
// one-cycle rvalid pulse, and transfers that never complete are aborted.
module pmu_ahb_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            we_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [N_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic                        hsel_o,
  output logic [ADDR_WIDTH-1:0]       haddr_o,
  output logic                        hwrite_o,
  output logic [1:0]                  htrans_o,
  output logic [2:0]                  hsize_o,
  output logic [2:0]                  hburst_o,
  output logic [DATA_WIDTH-1:0]       hwdata_o,
  input  logic                        hready_i,
  input  logic [DATA_WIDTH-1:0]       hrdata_i,
  input  logic [1:0]                  hresp_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W-1:0]        winner;
  logic                    any_req;
  logic [N_REQ-1:0]        win_oh;
  logic [N_REQ-1:0]        sel_oh;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [CNT_W-1:0]        cnt;

  // Word-sized single transfers only.
  assign hsize_o  = 3'b010;
  assign hburst_o = 3'b000;
  assign busy_o   = (state != IDLE);

  assign win_oh = N_REQ'(1) << winner;
  assign sel_oh = N_REQ'(1) << sel_idx;

  // Round-robin pick: scan from the requester after last_grant, wrapping once.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = last_grant;
    any_req = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        winner  = idx[IDX_W-1:0];
      end
    end
  end

  // Transfer sequencer: arbitration, address phase, data phase with timeout.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      sel_idx    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      gnt_o      <= '0;
      rvalid_o   <= '0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
      hsel_o     <= 1'b0;
      haddr_o    <= '0;
      hwrite_o   <= 1'b0;
      htrans_o   <= TRANS_IDLE;
      hwdata_o   <= '0;
    end else begin
      gnt_o    <= '0;
      rvalid_o <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ADDR;
            gnt_o      <= win_oh;
            last_grant <= winner;
            sel_idx    <= winner;
            we_q       <= we_i[winner];
            wdata_q    <= wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
            hsel_o     <= 1'b1;
            htrans_o   <= TRANS_NONSEQ;
            haddr_o    <= addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            hwrite_o   <= we_i[winner];
          end
        end
        ADDR: begin
          // Address phase is held unchanged until the slave accepts it.
          if (hready_i) begin
            state    <= DATA;
            hsel_o   <= 1'b0;
            htrans_o <= TRANS_IDLE;
            haddr_o  <= '0;
            hwrite_o <= 1'b0;
            hwdata_o <= we_q ? wdata_q : '0;
            cnt      <= '0;
          end
        end
        DATA: begin
          if (hready_i) begin
            state    <= IDLE;
            rvalid_o <= sel_oh;
            rdata_o  <= we_q ? '0 : hrdata_i;
            err_o    <= (hresp_i == RESP_ERROR);
            hwdata_o <= '0;
            cnt      <= '0;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            // Slave never answered: abort and report an error with no data.
            state    <= IDLE;
            rvalid_o <= sel_oh;
            rdata_o  <= '0;
            err_o    <= 1'b1;
            hwdata_o <= '0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
